// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: IDLE/REQ/WAIT/HOLD sequencing with redirect and kill handling.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_op,
  input  logic        br,
  input  logic [31:0] offset,
  input  logic [31:0] alu_c,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] target_raw, target;
  logic        trap, frozen;

  always_comb begin
    case (redirect_op)
      2'd0:    target_raw = redirect_pc + 32'd4;
      2'd1:    target_raw = alu_c;
      2'd2:    target_raw = redirect_pc + offset;
      default: target_raw = br ? (redirect_pc + offset) : (redirect_pc + 32'd4);
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign target     = target_raw;
  assign trap       = redirect_valid && !misalign_q && (target_raw[1:0] != 2'b00);
  assign misalign_d = misalign_q | trap;
  assign frozen     = misalign_q;
  assign misalign   = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  assign target   = target_raw & ~32'd3;
  assign trap     = 1'b0;
  assign frozen   = 1'b0;
  assign misalign = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_inst_d  = if_inst_q;

    if (frozen) begin
      state_d = IDLE;
    end else if (redirect_valid) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      if (trap) begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end else if ((state_q == REQ && imem_gnt) || (state_q == WAIT && !imem_rvalid)) begin
        // A fetch is in flight: its response must be swallowed before re-requesting.
        state_d = WAIT;
        kill_d  = 1'b1;
      end else begin
        state_d = REQ;
        kill_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  if (imem_gnt) state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = REQ;
            end else begin
              if_inst_d  = imem_rdata;
              if_pc_d    = pc_q;
              if_pc4_d   = pc_q + 32'd4;
              if_valid_d = 1'b1;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_d       = pc_q + 32'd4;
            if_valid_d = 1'b0;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_pc4_q   <= 32'd0;
      if_inst_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc4_q;
  assign if_inst   = if_inst_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: redirect_valid  input  1  execute stage requests a PC change this cycle.
REQ-005 SHALL have port: redirect_op  input  2  0 PC4, 1 ALU, 2 JUMP, 3 BR.
REQ-006 SHALL have ports: br  input  1  branch taken; offset  input  32  immediate; alu_c  input  32  ALU result; redirect_pc  input  32  PC of the redirecting instruction.
REQ-007 SHALL have port: stall  input  1  decode cannot accept if_inst this cycle.
REQ-008 SHALL have ports: imem_req  output  1; imem_addr  output  32; imem_gnt  input  1; imem_rvalid  input  1; imem_rdata  input  32.
REQ-009 SHALL have ports: if_valid  output  1; if_pc  output  32; if_pc4  output  32; if_inst  output  32.
REQ-010 SHALL have port: misalign  output  1  fetch-target misalignment flag (see Configuration).

Function
REQ-011 SHALL implement states IDLE, REQ, WAIT and HOLD.
REQ-012 IDLE: outputs quiescent; SHALL go to REQ on the next edge.
REQ-013 REQ: imem_req=1, imem_addr=pc; on imem_gnt SHALL go to WAIT; imem_addr SHALL stay stable until imem_gnt.
REQ-014 WAIT: on imem_rvalid SHALL capture imem_rdata into if_inst, capture pc into if_pc and pc+4 into if_pc4, and go to HOLD.
REQ-015 HOLD: if_valid=1; with stall=0 the instruction is consumed, pc becomes pc+4 and the state becomes REQ; with stall=1 all if_* outputs SHALL hold.
REQ-016 Redirect target SHALL be computed as follows: op0 redirect_pc+4; op1 alu_c; op2 redirect_pc+offset; op3 redirect_pc+offset if br else redirect_pc+4.
REQ-017 All 32-bit additions SHALL wrap modulo 2^32.
REQ-018 On redirect_valid, pc SHALL load the target on that edge, if_valid SHALL be 0 from the next cycle, and the state SHALL become REQ.
REQ-019 Redirect SHALL take priority over stall and over instruction consumption.
REQ-020 Redirect in REQ without gnt: SHALL withdraw the request and re-request at the target the next cycle.
REQ-021 Redirect in REQ with gnt the same cycle, or in WAIT: SHALL set a kill flag.
REQ-022 While the kill flag is set the block SHALL stay in WAIT, discard the next imem_rvalid, clear the flag, then go to REQ at the target.
REQ-023 imem_rvalid in WAIT coincident with redirect_valid SHALL be discarded, and the block SHALL go to REQ at the target.
REQ-024 imem_rvalid outside WAIT SHALL be ignored.
REQ-025 Minimum latency SHALL be: gnt in cycle N, rvalid in N+1, if_valid=1 in N+2.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_pc4=0, if_inst=0, misalign=0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding fetch, and its later rvalid SHALL be ignored.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN SHALL control misalignment trapping.
REQ-029 When FETCH_MISALIGN_TRAP_EN is defined, a redirect target with bits [1:0]!=0 SHALL set misalign=1 (sticky until reset), set pc to the target, and freeze the block in IDLE with imem_req=0.
REQ-030 When FETCH_MISALIGN_TRAP_EN is undefined, misalign SHALL be tied to 0 and target bits [1:0] SHALL be forced to 0 before loading pc.

Verification
REQ-031 Reset release with RESET_PC=0x100, gnt immediate, rvalid next cycle with data 0x00500093 -> if_valid=1 with if_pc=0x100, if_pc4=0x104, if_inst=0x00500093; next imem_addr=0x104.
REQ-032 stall=1 for 3 cycles in HOLD -> if_* stable for 3 cycles and no imem_req; stall=0 -> request at pc+4.
REQ-033 Redirect op3, br=1, redirect_pc=0x200, offset=0xFFFFFFF0 -> next imem_addr=0x1F0; repeat with br=0 -> imem_addr=0x204.
REQ-034 Redirect op1 with alu_c=0x3000 in WAIT, then rvalid with data 0xDEAD -> 0xDEAD never appears on if_inst; next request at 0x3000.
REQ-035 Redirect op2, redirect_pc=0xFFFFFFFC, offset=8 -> imem_addr=0x4 (wrap-around).
REQ-036 Redirect op1 with alu_c=0x1002 -> with FETCH_MISALIGN_TRAP_EN: misalign=1 and no further imem_req; without it: imem_addr=0x1000.
